// File: rtl/tt_um_hamming_encoder_7_4.sv
// rtl/tt_um_hamming_encoder_7_4.sv - Hamming(7,4) encoder with serial codeword output
// Accepts one nibble per frame, optionally corrupts one position, and shifts 7 bits out MSB first.
module tt_um_hamming_encoder_7_4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] data_in,
  input  logic       data_valid,
  input  logic [2:0] err_pos,
  output logic       data_ready,
  output logic       encode_out,
  output logic       bit_valid,
  output logic       frame_start
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t     state;
  logic [2:0] idx;
  logic [6:0] sr;
  logic [6:0] load_word;
  logic       last_bit;
  logic       accept;

  // Position k maps to sr[7-k]; err_pos=0 matches no bit, so the word passes untouched.
  function automatic logic [6:0] encode(input logic [3:0] d, input logic [2:0] ep);
    logic       d1, d2, d3, d4;
    logic [6:0] cw;
    logic [6:0] mask;
    d1   = d[3];
    d2   = d[2];
    d3   = d[1];
    d4   = d[0];
    cw   = {d1 ^ d2 ^ d4, d1 ^ d3 ^ d4, d1, d2 ^ d3 ^ d4, d2, d3, d4};
    mask = '0;
    for (int i = 0; i < 7; i++) begin
      mask[i] = (ep == 3'(7 - i));
    end
    return cw ^ mask;
  endfunction

  assign load_word = encode(data_in, err_pos);
  assign last_bit  = (state == SEND) && (idx == 3'd6);

  // rst_n gates the combinational outputs so nothing is offered while reset is held.
  assign data_ready  = rst_n && ena && ((state == IDLE) || last_bit);
  assign accept      = data_valid && data_ready;
  assign bit_valid   = rst_n && ena && (state == SEND);
  assign frame_start = bit_valid && (idx == 3'd0);
  assign encode_out  = (state == SEND) && sr[6];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= 3'd0;
      sr    <= 7'd0;
    end else if (ena) begin
      if (accept) begin
        state <= SEND;
        idx   <= 3'd0;
        sr    <= load_word;
      end else if (state == SEND) begin
        if (idx == 3'd6) begin
          state <= IDLE;
          idx   <= 3'd0;
          sr    <= 7'd0;
        end else begin
          idx <= idx + 3'd1;
          sr  <= {sr[5:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_tt_um_hamming_encoder_7_4.sv
// tb/tb_tt_um_hamming_encoder_7_4.sv - scoreboard bench for the Hamming(7,4) serial encoder
// Driver pushes expected bits on acceptance; a negedge monitor pops and compares every valid bit.
module tb_tt_um_hamming_encoder_7_4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [3:0] data_in = 4'd0;
  logic       data_valid = 1'b0;
  logic [2:0] err_pos = 3'd0;
  logic       data_ready;
  logic       encode_out;
  logic       bit_valid;
  logic       frame_start;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Each entry: [1] = expected frame_start, [0] = expected encode_out.
  logic [1:0] exp_q[$];

  tt_um_hamming_encoder_7_4 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .data_in    (data_in),
    .data_valid (data_valid),
    .err_pos    (err_pos),
    .data_ready (data_ready),
    .encode_out (encode_out),
    .bit_valid  (bit_valid),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present a word and hold data_valid until accepted; waits = cycles spent with data_ready low.
  task automatic send(input logic [3:0] d, input logic [2:0] e, input logic [6:0] cw,
                      output int waits);
    bit got;
    got = 1'b0;
    waits = 0;
    data_in = d;
    err_pos = e;
    data_valid = 1'b1;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (data_ready) got = 1'b1;
      else waits++;
      @(posedge clk);
      if (got) begin
        for (int i = 6; i >= 0; i--) exp_q.push_back({i == 6, cw[i]});
      end
      #1;
    end
    data_valid = 1'b0;
    check("accept_timeout", int'(got), 1);
  endtask

  always @(negedge clk) begin
    logic [1:0] e;
    if (bit_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_bit", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("encode_out", int'(encode_out), int'(e[0]));
        check("frame_start", int'(frame_start), int'(e[1]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    ena = 1'b1;
    #2;
    check("rst_data_ready", int'(data_ready), 0);
    check("rst_bit_valid", int'(bit_valid), 0);
    check("rst_encode_out", int'(encode_out), 0);
    check("rst_frame_start", int'(frame_start), 0);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", int'(data_ready), 1);
    check("idle_encode_out", int'(encode_out), 0);
    ena = 1'b0;
    #1;
    check("ena_low_ready", int'(data_ready), 0);
    data_valid = 1'b1;
    cyc();
    cyc();
    data_valid = 1'b0;
    ena = 1'b1;
    @(negedge clk);
    check("ignored_valid_bit_valid", int'(bit_valid), 0);
    cyc();

    // Basic 1011 with first-bit latency check.
    send(4'b1011, 3'd0, 7'b0110011, w);
    @(negedge clk);
    check("latency_bit_valid", int'(bit_valid), 1);
    check("latency_frame_start", int'(frame_start), 1);
    check("busy_ready", int'(data_ready), 0);
    cyc();
    repeat (8) cyc();

    // Extremes back-to-back; the second word must wait exactly through bits 1..6.
    send(4'b0000, 3'd0, 7'b0000000, w);
    send(4'b1111, 3'd0, 7'b1111111, w);
    check("b2b_wait_1111", w, 6);
    send(4'b1011, 3'd3, 7'b0100011, w);
    check("b2b_wait_err3", w, 6);
    send(4'b1011, 3'd7, 7'b0110010, w);
    check("b2b_wait_err7", w, 6);
    repeat (9) cyc();
    @(negedge clk);
    check("idle_after_frames", int'(encode_out), 0);
    cyc();

    // Stall of three cycles after bit 2.
    send(4'b1011, 3'd0, 7'b0110011, w);
    cyc();
    ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_bit_valid", int'(bit_valid), 0);
      check("stall_ready", int'(data_ready), 0);
      check("stall_frame_start", int'(frame_start), 0);
      check("stall_hold_out", int'(encode_out), 1);
      cyc();
    end
    ena = 1'b1;
    repeat (8) cyc();

    // Reset during bit 4, then a fresh 0101 frame.
    send(4'b1011, 3'd0, 7'b0110011, w);
    cyc();
    cyc();
    cyc();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_encode_out", int'(encode_out), 0);
    check("midrst_bit_valid", int'(bit_valid), 0);
    check("midrst_frame_start", int'(frame_start), 0);
    check("midrst_ready", int'(data_ready), 0);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", int'(data_ready), 1);
    check("post_rst_bit_valid", int'(bit_valid), 0);
    cyc();
    send(4'b0101, 3'd0, 7'b0100101, w);
    check("post_rst_wait", w, 0);
    repeat (10) cyc();

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
